// File: rtl/l1_wishbone_bridge_pkg.sv
// l1_wishbone_bridge_pkg: shared FSM state type and Wishbone cycle-type / burst-type encodings.
package l1_wishbone_bridge_pkg;
    typedef enum logic [1:0] {IDLE, READ, WRITE} wb_bridge_state_t;
    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_INCR = 3'b010;
    localparam logic [2:0] WB_CTI_END = 3'b111;
    localparam logic [1:0] WB_BTE_LINEAR = 2'b00;
endpackage

// File: rtl/l1_wishbone_bridge_if.sv
// l1_wishbone_bridge_if: L1 request, L1 return and Wishbone B4 bundles.
//   l1_arbiter_request_interface: addr/data/rnw/be/size/is_amo/amo/request toward the bridge, ack back.
//   l1_arbiter_return_interface:  data/data_valid/inv_addr/inv_valid from the bridge, inv_ack back.
//   wishbone_interface:           adr/dat_w/sel/cyc/stb/we/cti/bte from the master, dat_r/ack/err back.
interface l1_arbiter_request_interface;
    logic [31:0] addr;
    logic [31:0] data;
    logic rnw;
    logic [3:0] be;
    logic [4:0] size;
    logic is_amo;
    logic [4:0] amo;
    logic request;
    logic ack;
    modport master (output addr, data, rnw, be, size, is_amo, amo, request, input ack);
    modport slave (input addr, data, rnw, be, size, is_amo, amo, request, output ack);
endinterface

interface l1_arbiter_return_interface;
    logic [31:0] data;
    logic data_valid;
    logic [31:0] inv_addr;
    logic inv_valid;
    logic inv_ack;
    modport master (input data, data_valid, inv_addr, inv_valid, output inv_ack);
    modport slave (output data, data_valid, inv_addr, inv_valid, input inv_ack);
endinterface

interface wishbone_interface;
    logic [29:0] adr;
    logic [31:0] dat_w;
    logic [3:0] sel;
    logic cyc;
    logic stb;
    logic we;
    logic [2:0] cti;
    logic [1:0] bte;
    logic [31:0] dat_r;
    logic ack;
    logic err;
    modport master (output adr, dat_w, sel, cyc, stb, we, cti, bte, input dat_r, ack, err);
    modport slave (input adr, dat_w, sel, cyc, stb, we, cti, bte, output dat_r, ack, err);
endinterface

// File: rtl/l1_wishbone_bridge_watchdog.sv
// l1_wishbone_bridge_watchdog: beat watchdog, built only with CVA5_WB_BRIDGE_TIMEOUT_EN.
//   clk, rst_n : clock, async active-low reset
//   active_i   : strobe is up
//   clear_i    : slave terminated the beat (ack/err)
//   expire_o   : beat has waited TIMEOUT_CYCLES strobe cycles without termination
`ifdef CVA5_WB_BRIDGE_TIMEOUT_EN
module l1_wishbone_bridge_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic clear_i,
    output logic expire_o
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    // Counter reads k-1 during the k-th strobe cycle, so expiry lands on the TIMEOUT_CYCLES-th.
    assign expire_o = active_i && !clear_i && cnt_q == W'(TIMEOUT_CYCLES - 1);
    assign cnt_d = (!active_i || clear_i || expire_o) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule
`endif

// File: rtl/l1_wishbone_bridge.sv
// l1_wishbone_bridge: L1 arbiter requests to Wishbone B4 registered-feedback cycles.
//   clk, rst_n  : clock, async active-low reset
//   l1_request  : request slave (ack pulses once per accepted request)
//   l1_response : read data return (data_valid per beat; invalidation unused)
//   wb          : Wishbone master (incrementing read bursts, single-beat writes)
//   bus_error   : one-cycle pulse when a beat ends with err or timeout
// Optional watchdog: define CVA5_WB_BRIDGE_TIMEOUT_EN.
module l1_wishbone_bridge
    import l1_wishbone_bridge_pkg::*;
#(
    parameter bit USE_BURST_CTI = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    l1_arbiter_request_interface.slave l1_request,
    l1_arbiter_return_interface.slave l1_response,
    wishbone_interface.master wb,
    output logic bus_error
);
    wb_bridge_state_t state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [29:0] adr_q, adr_d;
    logic [31:0] dat_w_q, dat_w_d, data_q, data_d;
    logic [3:0] be_q, be_d;
    logic ack_q, ack_d, data_valid_q, data_valid_d, bus_error_q, bus_error_d;
    logic expire, beat_bad, beat_end;
    logic unused_ok;

`ifdef CVA5_WB_BRIDGE_TIMEOUT_EN
    l1_wishbone_bridge_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) watchdog_i (
        .clk(clk),
        .rst_n(rst_n),
        .active_i(state_q != IDLE),
        .clear_i(wb.ack | wb.err),
        .expire_o(expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    // Atomics run as plain accesses and invalidation is not supported.
    assign unused_ok = ^{l1_request.addr[1:0], l1_request.is_amo, l1_request.amo, l1_response.inv_ack};

    // An err (alone or with ack) or a watchdog expiry ends the beat as an error.
    assign beat_bad = wb.err | expire;
    assign beat_end = wb.ack | beat_bad;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        adr_d = adr_q;
        dat_w_d = dat_w_q;
        be_d = be_q;
        data_d = data_q;
        ack_d = 1'b0;
        data_valid_d = 1'b0;
        bus_error_d = 1'b0;
        case (state_q)
            IDLE: if (l1_request.request) begin
                ack_d = 1'b1;
                adr_d = l1_request.addr[31:2];
                dat_w_d = l1_request.data;
                be_d = l1_request.be;
                cnt_d = l1_request.size;
                state_d = l1_request.rnw ? READ : WRITE;
            end
            READ: if (beat_end) begin
                data_valid_d = 1'b1;
                data_d = beat_bad ? 32'h0 : wb.dat_r;
                bus_error_d = beat_bad;
                state_d = cnt_q == 5'd0 ? IDLE : READ;
                cnt_d = cnt_q == 5'd0 ? cnt_q : cnt_q - 5'd1;
                adr_d = cnt_q == 5'd0 ? adr_q : adr_q + 30'd1;
            end
            WRITE: if (beat_end) begin
                bus_error_d = beat_bad;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            adr_q <= '0;
            dat_w_q <= '0;
            be_q <= '0;
            data_q <= '0;
            ack_q <= 1'b0;
            data_valid_q <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            adr_q <= adr_d;
            dat_w_q <= dat_w_d;
            be_q <= be_d;
            data_q <= data_d;
            ack_q <= ack_d;
            data_valid_q <= data_valid_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign l1_request.ack = ack_q;
    assign l1_response.data = data_q;
    assign l1_response.data_valid = data_valid_q;
    assign l1_response.inv_addr = '0;
    assign l1_response.inv_valid = 1'b0;
    assign bus_error = bus_error_q;

    assign wb.cyc = state_q != IDLE;
    assign wb.stb = state_q != IDLE;
    assign wb.we = state_q == WRITE;
    assign wb.adr = adr_q;
    assign wb.dat_w = dat_w_q;
    assign wb.sel = state_q == WRITE ? be_q : state_q == READ ? 4'hF : 4'h0;
    assign wb.cti = (state_q == IDLE || !USE_BURST_CTI) ? WB_CTI_CLASSIC :
                    (state_q == WRITE || cnt_q == 5'd0) ? WB_CTI_END : WB_CTI_INCR;
    assign wb.bte = WB_BTE_LINEAR;
endmodule

// File: tb/tb_l1_wishbone_bridge.sv
// tb_l1_wishbone_bridge: scoreboard bench for l1_wishbone_bridge.
module tb_l1_wishbone_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bus_error;
    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    l1_arbiter_request_interface req_if();
    l1_arbiter_return_interface rsp_if();
    wishbone_interface wb_if();

    l1_wishbone_bridge #(.USE_BURST_CTI(1'b1), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .l1_request(req_if),
        .l1_response(rsp_if),
        .wb(wb_if),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every data_valid must match the oldest expected {bus_error, data}.
    always @(negedge clk) begin
        if (rst_n && rsp_if.data_valid) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("sb_data", rsp_if.data, mon_e[31:0]);
                chk("sb_bus_error", 32'(bus_error), 32'(mon_e[32]));
            end
        end
    end

    // Called at a negedge with the bridge idle; returns at the negedge where cyc has dropped.
    task automatic do_read(input logic [31:0] a, input int n, input int err_beat);
        logic [29:0] ea;
        logic [31:0] d;
        ea = a[31:2];
        req_if.addr = a;
        req_if.rnw = 1'b1;
        req_if.size = 5'(n - 1);
        req_if.request = 1'b1;
        @(negedge clk);
        req_if.request = 1'b0;
        chk("rd_req_ack", 32'(req_if.ack), 32'd1);
        chk("rd_first_dv", 32'(rsp_if.data_valid), 32'd0);
        for (int b = 0; b < n; b++) begin
            chk("rd_stb", 32'(wb_if.stb), 32'd1);
            chk("rd_adr", 32'(wb_if.adr), 32'(ea));
            chk("rd_cti", 32'(wb_if.cti), (b == n - 1) ? 32'd7 : 32'd2);
            chk("rd_we_sel", 32'({wb_if.we, wb_if.sel}), 32'h0F);
            d = $urandom;
            wb_if.dat_r = d;
            wb_if.ack = (b != err_beat);
            wb_if.err = (b == err_beat);
            exp_q.push_back({b == err_beat, (b == err_beat) ? 32'h0 : d});
            @(negedge clk);
            wb_if.ack = 1'b0;
            wb_if.err = 1'b0;
            chk("rd_dv_latency", 32'(rsp_if.data_valid), 32'd1);
            ea = ea + 30'd1;
        end
        chk("rd_cyc_drop", 32'(wb_if.cyc), 32'd0);
        chk("rd_no_ack", 32'(req_if.ack), 32'd0);
    endtask

    // ws wait states before the slave acks; with hold the request stays high meanwhile.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input int ws, input bit hold);
        req_if.addr = a;
        req_if.data = d;
        req_if.be = be;
        req_if.rnw = 1'b0;
        req_if.size = 5'd0;
        req_if.request = 1'b1;
        @(negedge clk);
        req_if.request = hold;
        chk("wr_req_ack", 32'(req_if.ack), 32'd1);
        chk("wr_cyc_stb_we", 32'({wb_if.cyc, wb_if.stb, wb_if.we}), 32'h7);
        chk("wr_adr", 32'(wb_if.adr), 32'(a >> 2));
        chk("wr_sel", 32'(wb_if.sel), 32'(be));
        chk("wr_cti", 32'(wb_if.cti), 32'd7);
        chk("wr_dat_w", wb_if.dat_w, d);
        for (int w = 0; w < ws; w++) begin
            @(negedge clk);
            chk("wr_wait_no_ack", 32'(req_if.ack), 32'd0);
            chk("wr_wait_stb", 32'(wb_if.stb), 32'd1);
        end
        req_if.request = 1'b0;
        wb_if.ack = 1'b1;
        @(negedge clk);
        wb_if.ack = 1'b0;
        chk("wr_cyc_drop", 32'(wb_if.cyc), 32'd0);
        chk("wr_no_dv", 32'(rsp_if.data_valid), 32'd0);
        chk("wr_no_berr", 32'(bus_error), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        req_if.request = 1'b0;
        req_if.addr = '0;
        req_if.data = '0;
        req_if.rnw = 1'b0;
        req_if.be = '0;
        req_if.size = '0;
        req_if.is_amo = 1'b0;
        req_if.amo = '0;
        rsp_if.inv_ack = 1'b0;
        wb_if.dat_r = '0;
        wb_if.ack = 1'b0;
        wb_if.err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc_stb_we", 32'({wb_if.cyc, wb_if.stb, wb_if.we}), 32'h0);
        chk("rst_adr", 32'(wb_if.adr), 32'h0);
        chk("rst_dat_w", wb_if.dat_w, 32'h0);
        chk("rst_sel_cti_bte", 32'({wb_if.sel, wb_if.cti, wb_if.bte}), 32'h0);
        chk("rst_ack_dv_berr", 32'({req_if.ack, rsp_if.data_valid, bus_error}), 32'h0);
        chk("rst_data", rsp_if.data, 32'h0);
        chk("rst_inv", 32'({rsp_if.inv_valid, rsp_if.inv_addr != 32'h0}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        do_write(32'h0000_1004, 32'hDEAD_BEEF, 4'b0110, 0, 1'b0);
        do_write(32'h0000_2008, 32'h1234_5678, 4'b1001, 3, 1'b1);
        do_read(32'h0000_0100, 4, -1);
        do_read(32'hFFFF_FFFC, 2, -1);
        do_read(32'h0000_0400, 3, 1);
        req_if.is_amo = 1'b1;
        req_if.amo = 5'h1F;
        do_read(32'h0000_0800, 1, -1);
        do_write(32'h0000_0810, 32'hCAFE_F00D, 4'b1111, 1, 1'b0);
        req_if.is_amo = 1'b0;
        do_read(32'h0000_0C00, 32, 31);
        // Reset during the third beat of an eight-word read.
        req_if.addr = 32'h0000_2000;
        req_if.rnw = 1'b1;
        req_if.size = 5'd7;
        req_if.request = 1'b1;
        @(negedge clk);
        req_if.request = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wb_if.dat_r = 32'hA000_0000 + 32'(b);
            wb_if.ack = 1'b1;
            exp_q.push_back({1'b0, 32'hA000_0000 + 32'(b)});
            @(negedge clk);
            wb_if.ack = 1'b0;
        end
        chk("mid_adr_beat3", 32'(wb_if.adr), 32'h802);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc_stb", 32'({wb_if.cyc, wb_if.stb}), 32'h0);
        chk("mid_rst_dv", 32'(rsp_if.data_valid), 32'd0);
        chk("mid_rst_adr_sel", 32'({wb_if.adr != 30'h0, wb_if.sel}), 32'h0);
        chk("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("mid_rst_held_dv", 32'(rsp_if.data_valid), 32'd0);
        rst_n = 1'b1;
        do_read(32'h0000_0040, 1, -1);
`ifdef CVA5_WB_BRIDGE_TIMEOUT_EN
        begin
            int n;
            req_if.addr = 32'h0000_3000;
            req_if.rnw = 1'b0;
            req_if.size = 5'd0;
            req_if.request = 1'b1;
            @(negedge clk);
            req_if.request = 1'b0;
            chk("to_req_ack", 32'(req_if.ack), 32'd1);
            n = 0;
            while (wb_if.stb && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("to_stb_cycles", 32'(n), 32'd16);
            chk("to_bus_error", 32'(bus_error), 32'd1);
            chk("to_cyc_drop", 32'(wb_if.cyc), 32'd0);
            do_read(32'h0000_0080, 1, -1);
        end
`endif
        @(negedge clk);
        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("end_idle", 32'({wb_if.cyc, rsp_if.data_valid, req_if.ack}), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l1_wishbone_bridge.md
Name: l1_wishbone_bridge

Overview:
- Converts L1 arbiter requests into Wishbone B4 registered-feedback bus cycles for a single 32-bit Wishbone memory or peripheral.
- Sits directly downstream of the L1 arbiter.
- Takes requests on an l1_arbiter_request_interface slave port, drives a wishbone_interface master port, and returns read data on an l1_arbiter_return_interface slave port.
- Reads are incrementing bursts of size+1 words; writes are single beats.

Parameters:
- USE_BURST_CTI, 1: 1 = drive cti 010 (incrementing) / 111 (end-of-burst); 0 = drive cti 000 (classic) on all beats.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; only used when the optional feature is compiled in.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset; all state is cleared while low.
- l1_request  l1_arbiter_request_interface.slave  -  addr, data, rnw, be, size, is_amo, amo, request in; ack out.
- l1_response  l1_arbiter_return_interface.slave  -  data, data_valid, inv_addr, inv_valid out; inv_ack in.
- wb  wishbone_interface.master  -  adr, dat_w, sel, cyc, stb, we, cti, bte out; dat_r, ack, err in.
- bus_error  output  1  one-cycle pulse when a beat terminates with err or by timeout.

Behaviour:
- Reset values: ack=0, data_valid=0, data=0, inv_valid=0, inv_addr=0, cyc=0, stb=0, we=0, adr=0, dat_w=0, sel=0, cti=000, bte=00, bus_error=0.
- Invalidation is not supported: inv_valid tied 0; inv_ack ignored.
- FSM states: IDLE, READ, WRITE.
- IDLE accepting a request (request=1):
  - ack pulses high for exactly one cycle, on the next edge.
  - Latch addr, data, be, rnw, size on that same edge.
  - Load beat counter = size.
  - Next state: READ if rnw=1, else WRITE.
  - cyc=stb=1 from the same edge.
- No further request is accepted until the FSM returns to IDLE. ack is never asserted outside IDLE.
- is_amo=1 requests are executed as plain reads/writes; amo is ignored.
- Bus fields: adr = addr[31:2]; bte = 00 (linear).
- WRITE state:
  - we=1, dat_w = latched data, sel = latched be, cti = 111.
  - On the first wb.ack or wb.err: drop cyc/stb on the next edge and return to IDLE.
- READ state:
  - we=0, sel=1111.
  - cti = 010 while the beat counter is nonzero, 111 when it is zero (000 throughout if USE_BURST_CTI=0).
  - On each wb.ack:
    - The cycle after the ack, register dat_r into l1_response.data and pulse data_valid for one cycle.
    - If counter≠0: decrement the counter, adr+1 (30-bit wrap, 3FFFFFFF→00000000), keep stb=1.
    - If counter=0: drop cyc/stb on the next edge and return to IDLE.
- wb.err during a read:
  - Treated as an ack for sequencing.
  - data returned = 0, data_valid still pulsed.
  - bus_error pulsed, aligned with data_valid.
- Total words returned per read = size+1, range 1..32.
- Latency:
  - Request to first stb: 1 cycle.
  - wb.ack to data_valid: 1 cycle.
  - Last ack to IDLE: 1 cycle.
  - Back-to-back: minimum one IDLE cycle between transactions.
- ack and err asserted together count as a single beat with error.
- rst_n falling mid-burst:
  - Immediately forces IDLE with all outputs at reset values.
  - Remaining beats are abandoned; no data_valid is produced for them.

Optional Feature:
- Macro: CVA5_WB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on every stb accept (ack/err) and on entering READ or WRITE.
  - When it reaches TIMEOUT_CYCLES with stb=1 and no ack/err, the current beat terminates as an error: bus_error pulse; for reads, data=0 with data_valid.
  - The sequence then continues exactly as for wb.err.
- Undefined: no counter; the bridge waits indefinitely for ack/err.

Decomposition:
- l2_config_and_types gains:
  - wb_bridge_state_t enum {IDLE, READ, WRITE};
  - constants WB_CTI_CLASSIC=3'b000, WB_CTI_INCR=3'b010, WB_CTI_END=3'b111, WB_BTE_LINEAR=2'b00.
- One sub-module, wb_bridge_watchdog (counter plus expire output), instantiated only under CVA5_WB_BRIDGE_TIMEOUT_EN.
- Beat counter and address stay inline.

Test Plan:
- Write addr=0x0000_1004, data=0xDEADBEEF, be=0110, size=0 → one beat with adr=0x401, we=1, sel=0110, cti=111; ack one cycle after request; cyc dropped the cycle after wb.ack; no data_valid.
- Read addr=0x100, size=3, slave acks every cycle → adr 0x40,0x41,0x42,0x43; cti 010,010,010,111; four data_valid pulses each 1 cycle after their ack, data matching dat_r.
- Read addr=0xFFFF_FFFC, size=1 → adr 0x3FFFFFFF then 0x00000000; two data_valid pulses.
- Read size=2 with wb.err on beat 2 → data sequence [D0, 0, D2]; bus_error pulse coincident with the second data_valid; burst completes.
- rst_n driven low during beat 3 of a size=7 read → cyc/stb/data_valid=0 immediately; after release, a new size=0 read completes normally.
- With CVA5_WB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks a write → bus_error pulses after 16 cycles of stb; FSM returns to IDLE and accepts the next request.
